// File: rtl/mips_id_stage.sv
// MIPS instruction-decode stage: register file with write-back bypass, control decode,
// immediate/target generation, load-use hazard detection and the ID/EX pipeline register.
module mips_id_stage #(
    parameter int unsigned NB_DATA  = 32,
    parameter int unsigned NB_ADDR  = 5,
    parameter int unsigned NB_PC    = 32,
    parameter int unsigned LINK_REG = 31
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [31:0]        i_instruction,
    input  logic [NB_PC-1:0]   i_pcounter4,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_wb_we,
    input  logic [NB_ADDR-1:0] i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic               i_ex_memRead,
    input  logic [NB_ADDR-1:0] i_ex_wr_addr,
    output logic               o_hazard_stall,
    output logic               o_valid,
    output logic [NB_ADDR-1:0] o_rs,
    output logic [NB_ADDR-1:0] o_rt,
    output logic [NB_ADDR-1:0] o_rd,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_reg_DA,
    output logic [NB_DATA-1:0] o_reg_DB,
    output logic [NB_DATA-1:0] o_immediate,
    output logic [4:0]         o_shamt,
    output logic [5:0]         o_func,
    output logic [5:0]         o_opcode,
    output logic [NB_PC-1:0]   o_branch_target,
    output logic [NB_PC-1:0]   o_jump_target,
    output logic [NB_PC-1:0]   o_link,
    output logic               o_regWrite,
    output logic               o_memRead,
    output logic               o_memWrite,
    output logic               o_mem2Reg,
    output logic               o_branch,
    output logic               o_bne,
    output logic               o_jump,
    output logic               o_jr,
    output logic               o_illegal,
    output logic [1:0]         o_aluSrc,
    output logic [1:0]         o_aluOp
);

    localparam int unsigned NREGS = 2 ** NB_ADDR;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem2reg;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       jr;
        logic       illegal;
        logic [1:0] alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic               valid;
        logic [NB_ADDR-1:0] rs;
        logic [NB_ADDR-1:0] rt;
        logic [NB_ADDR-1:0] rd;
        logic [NB_ADDR-1:0] wr_addr;
        logic [NB_DATA-1:0] reg_da;
        logic [NB_DATA-1:0] reg_db;
        logic [NB_DATA-1:0] immediate;
        logic [4:0]         shamt;
        logic [5:0]         func;
        logic [5:0]         opcode;
        logic [NB_PC-1:0]   branch_target;
        logic [NB_PC-1:0]   jump_target;
        logic [NB_PC-1:0]   link;
        ctrl_t              ctrl;
    } idex_t;

    logic [NB_DATA-1:0] rf_q [NREGS];
    logic [5:0]         opcode;
    logic [5:0]         func;
    logic [4:0]         shamt;
    logic [15:0]        imm16;
    logic [NB_ADDR-1:0] rs;
    logic [NB_ADDR-1:0] rt;
    logic [NB_ADDR-1:0] rd;
    logic [NB_ADDR-1:0] wr_addr;
    logic [NB_DATA-1:0] reg_da;
    logic [NB_DATA-1:0] reg_db;
    logic [NB_DATA-1:0] immediate;
    logic [NB_PC-1:0]   branch_target;
    logic [NB_PC-1:0]   jump_target;
    logic               wb_hit;
    logic               zext_imm;
    logic               reads_rt;
    ctrl_t              ctrl;
    idex_t              idex_d;
    idex_t              idex_q;

    assign opcode = i_instruction[31:26];
    assign rs     = NB_ADDR'(i_instruction[25:21]);
    assign rt     = NB_ADDR'(i_instruction[20:16]);
    assign rd     = NB_ADDR'(i_instruction[15:11]);
    assign shamt  = i_instruction[10:6];
    assign func   = i_instruction[5:0];
    assign imm16  = i_instruction[15:0];

    // Register 0 is never written, so it need not be reset to read as zero.
    always_ff @(posedge clk) begin
        if (i_wb_we && (i_wb_addr != '0)) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    assign wb_hit = i_wb_we && (i_wb_addr != '0);

    always_comb begin
        reg_da = (rs == '0) ? '0 : rf_q[rs];
        reg_db = (rt == '0) ? '0 : rf_q[rt];
        if (wb_hit && (i_wb_addr == rs)) reg_da = i_wb_data;
        if (wb_hit && (i_wb_addr == rt)) reg_db = i_wb_data;
    end

    always_comb begin
        ctrl     = '0;
        wr_addr  = '0;
        zext_imm = 1'b0;
        reads_rt = 1'b0;
        case (opcode)
            6'b000000: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = 2'b10;
                wr_addr        = rd;
                reads_rt       = 1'b1;
                if (func inside {6'b000000, 6'b000010, 6'b000011}) ctrl.alu_src = 2'b10;
                if (func == 6'b001000) begin
                    ctrl.jump      = 1'b1;
                    ctrl.jr        = 1'b1;
                    ctrl.reg_write = 1'b0;
                end
            end
            6'b100011: begin
                ctrl.mem_read  = 1'b1;
                ctrl.mem2reg   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 2'b01;
                wr_addr        = rt;
            end
            6'b101011: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 2'b01;
                reads_rt       = 1'b1;
            end
            6'b000100, 6'b000101: begin
                ctrl.branch = 1'b1;
                ctrl.bne    = opcode[0];
                ctrl.alu_op = 2'b01;
                reads_rt    = 1'b1;
            end
            6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 2'b01;
                ctrl.alu_op    = 2'b11;
                wr_addr        = rt;
                zext_imm       = opcode[2];
            end
            6'b000010: ctrl.jump = 1'b1;
            6'b000011: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                wr_addr        = NB_ADDR'(LINK_REG);
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    assign immediate = zext_imm ? {{(NB_DATA - 16){1'b0}}, imm16}
                                : {{(NB_DATA - 16){imm16[15]}}, imm16};
    assign branch_target = i_pcounter4 + {{(NB_PC - 18){imm16[15]}}, imm16, 2'b00};

    always_comb begin
        jump_target       = i_pcounter4;
        jump_target[27:0] = {i_instruction[25:0], 2'b00};
    end

    assign o_hazard_stall = i_valid && i_ex_memRead && (i_ex_wr_addr != '0) &&
                            ((i_ex_wr_addr == rs) || (reads_rt && (i_ex_wr_addr == rt)));

    // Flush outranks stall; a load-use hazard only inserts a bubble when not stalled.
    always_comb begin
        idex_d = idex_q;
        if (i_flush) begin
            idex_d = '0;
        end else if (i_stall) begin
            idex_d = idex_q;
        end else if (o_hazard_stall) begin
            idex_d = '0;
        end else begin
            idex_d.valid         = i_valid;
            idex_d.rs            = rs;
            idex_d.rt            = rt;
            idex_d.rd            = rd;
            idex_d.wr_addr       = wr_addr;
            idex_d.reg_da        = reg_da;
            idex_d.reg_db        = reg_db;
            idex_d.immediate     = immediate;
            idex_d.shamt         = shamt;
            idex_d.func          = func;
            idex_d.opcode        = opcode;
            idex_d.branch_target = branch_target;
            idex_d.jump_target   = jump_target;
            idex_d.link          = i_pcounter4;
            idex_d.ctrl          = i_valid ? ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign o_valid         = idex_q.valid;
    assign o_rs            = idex_q.rs;
    assign o_rt            = idex_q.rt;
    assign o_rd            = idex_q.rd;
    assign o_wr_addr       = idex_q.wr_addr;
    assign o_reg_DA        = idex_q.reg_da;
    assign o_reg_DB        = idex_q.reg_db;
    assign o_immediate     = idex_q.immediate;
    assign o_shamt         = idex_q.shamt;
    assign o_func          = idex_q.func;
    assign o_opcode        = idex_q.opcode;
    assign o_branch_target = idex_q.branch_target;
    assign o_jump_target   = idex_q.jump_target;
    assign o_link          = idex_q.link;
    assign o_regWrite      = idex_q.ctrl.reg_write;
    assign o_memRead       = idex_q.ctrl.mem_read;
    assign o_memWrite      = idex_q.ctrl.mem_write;
    assign o_mem2Reg       = idex_q.ctrl.mem2reg;
    assign o_branch        = idex_q.ctrl.branch;
    assign o_bne           = idex_q.ctrl.bne;
    assign o_jump          = idex_q.ctrl.jump;
    assign o_jr            = idex_q.ctrl.jr;
    assign o_illegal       = idex_q.ctrl.illegal;
    assign o_aluSrc        = idex_q.ctrl.alu_src;
    assign o_aluOp         = idex_q.ctrl.alu_op;

endmodule

// File: tb/tb_mips_id_stage.sv
// Scoreboard bench for mips_id_stage: directed scenarios followed by randomized traffic,
// checked against a behavioural decode/pipeline model.
module tb_mips_id_stage;

    logic        clk = 1'b0;
    logic        i_rst_n, i_valid, i_stall, i_flush, i_wb_we, i_ex_memRead;
    logic [31:0] i_instruction, i_pcounter4, i_wb_data;
    logic [4:0]  i_wb_addr, i_ex_wr_addr;
    logic        o_hazard_stall, o_valid;
    logic [4:0]  o_rs, o_rt, o_rd, o_wr_addr, o_shamt;
    logic [31:0] o_reg_DA, o_reg_DB, o_immediate, o_branch_target, o_jump_target, o_link;
    logic [5:0]  o_func, o_opcode;
    logic        o_regWrite, o_memRead, o_memWrite, o_mem2Reg, o_branch, o_bne, o_jump, o_jr;
    logic        o_illegal;
    logic [1:0]  o_aluSrc, o_aluOp;

    always #5 clk = ~clk;

    mips_id_stage dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_instruction(i_instruction),
        .i_pcounter4(i_pcounter4), .i_stall(i_stall), .i_flush(i_flush), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_ex_memRead(i_ex_memRead),
        .i_ex_wr_addr(i_ex_wr_addr), .o_hazard_stall(o_hazard_stall), .o_valid(o_valid),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_wr_addr(o_wr_addr), .o_reg_DA(o_reg_DA),
        .o_reg_DB(o_reg_DB), .o_immediate(o_immediate), .o_shamt(o_shamt), .o_func(o_func),
        .o_opcode(o_opcode), .o_branch_target(o_branch_target), .o_jump_target(o_jump_target),
        .o_link(o_link), .o_regWrite(o_regWrite), .o_memRead(o_memRead),
        .o_memWrite(o_memWrite), .o_mem2Reg(o_mem2Reg), .o_branch(o_branch), .o_bne(o_bne),
        .o_jump(o_jump), .o_jr(o_jr), .o_illegal(o_illegal), .o_aluSrc(o_aluSrc),
        .o_aluOp(o_aluOp)
    );

    // ctl = {regWrite, memRead, memWrite, mem2Reg, branch, bne, jump, jr, illegal, aluSrc, aluOp}
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd, wr;
        logic [31:0] da, db, imm;
        logic [4:0]  shamt;
        logic [5:0]  func, op;
        logic [31:0] bt, jt, link;
        logic [12:0] ctl;
    } exp_t;

    typedef struct { int cyc; exp_t e; } out_ent_t;
    typedef struct { int cyc; logic hz; } hz_ent_t;

    out_ent_t    out_q[$];
    hz_ent_t     hz_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rf [32];
    exp_t        cur = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents against queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            while (hz_q.size() > 0 && hz_q[0].cyc <= cyc) begin
                hz_ent_t h;
                h = hz_q.pop_front();
                chk("hazard_stall", 64'(o_hazard_stall), 64'(h.hz));
            end
            while (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
                out_ent_t o;
                o = out_q.pop_front();
                chk("valid", 64'(o_valid), 64'(o.e.valid));
                chk("controls", 64'({o_regWrite, o_memRead, o_memWrite, o_mem2Reg, o_branch,
                                     o_bne, o_jump, o_jr, o_illegal, o_aluSrc, o_aluOp}),
                    64'(o.e.ctl));
                chk("wr_addr", 64'(o_wr_addr), 64'(o.e.wr));
                chk("reg_DA", 64'(o_reg_DA), 64'(o.e.da));
                chk("reg_DB", 64'(o_reg_DB), 64'(o.e.db));
                chk("immediate", 64'(o_immediate), 64'(o.e.imm));
                chk("branch_target", 64'(o_branch_target), 64'(o.e.bt));
                chk("jump_target", 64'(o_jump_target), 64'(o.e.jt));
                chk("link", 64'(o_link), 64'(o.e.link));
                chk("fields", {28'd0, o_rs, o_rt, o_rd, o_shamt, o_func, o_opcode},
                    {28'd0, o.e.rs, o.e.rt, o.e.rd, o.e.shamt, o.e.func, o.e.op});
            end
        end
    end

    function automatic logic [31:0] rf_model(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (i_wb_we && i_wb_addr == idx) return i_wb_data;
        return rf[idx];
    endfunction

    function automatic logic reads_rt(input logic [5:0] op);
        return op inside {6'h00, 6'h04, 6'h05, 6'h2B};
    endfunction

    // Decode described by instruction class rather than by opcode case.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc4);
        exp_t        e;
        logic [5:0]  op, fn;
        logic        is_r, is_lw, is_sw, is_beq, is_bne, is_ar, is_lg, is_j, is_jal, is_jr;
        logic        rw, ill;
        logic [1:0]  src, aop;
        op = ins[31:26];
        fn = ins[5:0];
        is_r = (op == 6'h00); is_lw = (op == 6'h23); is_sw = (op == 6'h2B);
        is_beq = (op == 6'h04); is_bne = (op == 6'h05);
        is_ar = op inside {6'h08, 6'h0A}; is_lg = op inside {[6'h0C:6'h0F]};
        is_j = (op == 6'h02); is_jal = (op == 6'h03); is_jr = is_r && (fn == 6'h08);
        rw  = (is_r && !is_jr) || is_lw || is_ar || is_lg || is_jal;
        ill = !(is_r || is_lw || is_sw || is_beq || is_bne || is_ar || is_lg || is_j || is_jal);
        src = is_r ? ((fn inside {6'h00, 6'h02, 6'h03}) ? 2'd2 : 2'd0)
                   : (is_lw || is_sw || is_ar || is_lg) ? 2'd1 : 2'd0;
        aop = is_r ? 2'd2 : (is_beq || is_bne) ? 2'd1 : (is_ar || is_lg) ? 2'd3 : 2'd0;
        e.valid = 1'b1;
        e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11];
        e.wr = is_r ? ins[15:11] : (is_lw || is_ar || is_lg) ? ins[20:16] : is_jal ? 5'd31 : 5'd0;
        e.da = rf_model(ins[25:21]);
        e.db = rf_model(ins[20:16]);
        e.imm = is_lg ? {16'd0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        e.shamt = ins[10:6]; e.func = fn; e.op = op;
        e.bt = pc4 + ({{16{ins[15]}}, ins[15:0]} * 32'd4);
        e.jt = {pc4[31:28], ins[25:0], 2'b00};
        e.link = pc4;
        e.ctl = {rw, is_lw, is_sw, is_lw, is_beq || is_bne, is_bne,
                 is_j || is_jal || is_jr, is_jr, ill, src, aop};
        return e;
    endfunction

    task automatic cycle(input logic rst_n, input logic valid, input logic [31:0] ins,
                         input logic [31:0] pc4, input logic stall, input logic flush,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic exmr, input logic [4:0] exwa);
        exp_t nxt;
        logic hz;
        i_rst_n = rst_n; i_valid = valid; i_instruction = ins; i_pcounter4 = pc4;
        i_stall = stall; i_flush = flush; i_wb_we = we; i_wb_addr = wa; i_wb_data = wd;
        i_ex_memRead = exmr; i_ex_wr_addr = exwa;
        hz = valid && exmr && (exwa != 5'd0) &&
             ((exwa == ins[25:21]) || (reads_rt(ins[31:26]) && exwa == ins[20:16]));
        if (!rst_n || flush)  nxt = '0;
        else if (stall)       nxt = cur;
        else if (hz)          nxt = '0;
        else begin
            nxt = ref_decode(ins, pc4);
            nxt.valid = valid;
            if (!valid) nxt.ctl = '0;
        end
        cur = nxt;
        hz_q.push_back('{cyc: cyc, hz: hz});
        out_q.push_back('{cyc: cyc + 1, e: nxt});
        if (we && wa != 5'd0) rf[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [13] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C,
                                  6'h0D, 6'h0E, 6'h0F, 6'h02, 6'h03};
        logic [5:0]  fns [8]  = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h22, 6'h25, 6'h2A};
        logic [31:0] ins;
        int          k;
        ins = $urandom;
        k = $urandom_range(0, 14);
        ins[31:26] = (k >= 13) ? 6'($urandom) : ops[k];
        if (ins[31:26] == 6'h00 && $urandom_range(0, 3) != 0) ins[5:0] = fns[$urandom_range(0, 7)];
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rf[0] = 32'd0;
        i_rst_n = 1'b0; i_valid = 1'b0; i_instruction = '0; i_pcounter4 = '0; i_stall = 1'b0;
        i_flush = 1'b0; i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0; i_ex_memRead = 1'b0;
        i_ex_wr_addr = '0;
        @(posedge clk);
        #1;
        cycle(0, 1, 32'h00221820, 32'h4, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 32; i++) cycle(1, 0, 32'h0, 32'h0, 0, 0, 1, 5'(i), $urandom, 0, 0);
        cycle(1, 0, 32'h0, 32'h0, 0, 0, 1, 5'd1, 32'd5, 0, 0);
        cycle(1, 0, 32'h0, 32'h0, 0, 0, 1, 5'd2, 32'd7, 0, 0);
        cycle(1, 1, 32'h00221820, 32'h100, 0, 0, 0, 0, 0, 0, 0);          // add r3,r1,r2
        cycle(1, 1, 32'h2022FFFF, 32'h104, 0, 0, 1, 5'd1, 32'hDEAD, 0, 0); // WB bypass
        cycle(1, 1, 32'h00802820, 32'h108, 0, 0, 0, 0, 0, 1, 5'd4);       // load-use
        cycle(1, 1, 32'h00802820, 32'h108, 0, 0, 0, 0, 0, 1, 5'd0);
        cycle(1, 1, 32'h00221820, 32'h10C, 1, 1, 0, 0, 0, 0, 0);          // flush beats stall
        cycle(1, 1, 32'h00221820, 32'h110, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h0C000010, 32'h40000004, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h1000FFFF, 32'h0, 0, 0, 0, 0, 0, 0, 0);            // branch wrap
        cycle(1, 1, 32'h0C000010, 32'h40000004, 0, 0, 0, 0, 0, 0, 0);     // jal
        cycle(1, 1, 32'hFC000000, 32'h200, 0, 0, 0, 0, 0, 0, 0);          // illegal
        cycle(1, 1, 32'h20020001, 32'h204, 0, 0, 1, 5'd0, 32'h1234, 0, 0);
        cycle(1, 1, 32'h00001020, 32'h208, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 32'h8C220004, 32'h20C, 0, 0, 0, 0, 0, 0, 0);          // invalid slot
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), rand_instr(),
                  $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
        end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(out_q.size() + hz_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_id_stage.md
Name: mips_id_stage

Overview:
Parametrised MIPS instruction-decode stage with integrated register file, control decode, immediate extension, branch/jump target generation, and load-use hazard detection. Sits between the IF/ID and EX stages. It owns the ID/EX pipeline register, which has a valid bit, hold (stall), bubble and flush behaviour. The write-back port writes the internal register file; same-cycle write-to-read is bypassed.

Parameters:
NB_DATA, 32, register and data width
NB_ADDR, 5, register index width (register file depth = 2**NB_ADDR)
NB_PC, 32, program-counter width (must be >= 28)
LINK_REG, 31, destination index for jal

Ports:
clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_valid  input  1  IF/ID slot holds a real instruction
i_instruction  input  32  instruction word
i_pcounter4  input  NB_PC  PC+4 of the instruction
i_stall  input  1  downstream hold; ID/EX register keeps its value
i_flush  input  1  squash; ID/EX register becomes a bubble
i_wb_we  input  1  write-back enable
i_wb_addr  input  NB_ADDR  write-back register index
i_wb_data  input  NB_DATA  write-back data
i_ex_memRead  input  1  instruction currently in EX is a load
i_ex_wr_addr  input  NB_ADDR  destination of the EX instruction
o_hazard_stall  output  1  combinational load-use stall request to PC and IF/ID
o_valid  output  1  ID/EX slot valid
o_rs, o_rt, o_rd  output  NB_ADDR each  instruction fields
o_wr_addr  output  NB_ADDR  resolved destination (rd / rt / LINK_REG)
o_reg_DA, o_reg_DB  output  NB_DATA each  operand values
o_immediate  output  NB_DATA  extended immediate
o_shamt  output  5  shift amount
o_func  output  6  function field
o_opcode  output  6  opcode, instruction bits [31:26]
o_branch_target  output  NB_PC  branch target
o_jump_target  output  NB_PC  jump target
o_link  output  NB_PC  PC+4 for jal
o_regWrite, o_memRead, o_memWrite, o_mem2Reg, o_branch, o_bne, o_jump, o_jr, o_illegal  output  1 each  control bits
o_aluSrc  output  2  00 = reg, 01 = imm, 10 = shamt
o_aluOp  output  2  00 = add, 01 = sub, 10 = funct, 11 = immediate-op

Behaviour:
- Register file: 2**NB_ADDR x NB_DATA.
  - Written on the rising clock edge when i_wb_we=1 and i_wb_addr!=0. Register 0 always reads 0.
  - Reads are combinational. If i_wb_we=1, i_wb_addr!=0 and i_wb_addr equals the read index, the read returns i_wb_data.
  - Reset does not clear the array; only register 0 is guaranteed 0.
- Decode (combinational), all unlisted bits 0:
  - R-type (000000): regWrite, aluOp=10, wr_addr=rd. funct 000000/000010/000011 additionally sets aluSrc=10. funct 001000 (jr) sets jump and jr, and clears regWrite.
  - lw (100011): memRead, mem2Reg, regWrite, aluSrc=01, aluOp=00, wr_addr=rt.
  - sw (101011): memWrite, aluSrc=01, aluOp=00.
  - beq (000100): branch, aluOp=01. bne (000101): branch, bne, aluOp=01.
  - addi (001000) and slti (001010): sign-extended immediate, regWrite, aluSrc=01, aluOp=11, wr_addr=rt.
  - andi/ori/xori/lui (001100/001101/001110/001111): zero-extended immediate, otherwise as addi.
  - j (000010): jump. jal (000011): jump, regWrite, wr_addr=LINK_REG.
  - Any other opcode: all controls 0 and illegal=1.
- Targets: branch_target = pcounter4 + (sext(imm)<<2), wrapping modulo 2**NB_PC. jump_target = {pcounter4[NB_PC-1:28], instr[25:0], 2'b00}. link = pcounter4.
- Hazard: o_hazard_stall = i_valid & i_ex_memRead & (i_ex_wr_addr!=0) & (ex_wr_addr==rs, or ex_wr_addr==rt when the instruction reads rt). Instructions that read rt: R-type, beq, bne, sw.
- ID/EX register update, priority top to bottom, one decision per rising edge:
  1. !i_rst_n: every output register is cleared to 0, including o_valid.
  2. i_flush: bubble. o_valid=0 and all control bits=0; data fields are don't-care and are driven to 0.
  3. i_stall: hold all values.
  4. o_hazard_stall: bubble, same as flush.
  5. Otherwise: load the decoded fields. o_valid=i_valid; if i_valid=0, all control bits=0.
- o_hazard_stall is not gated by i_stall. Upstream ORs the two.
- Latency: one cycle from IF/ID to ID/EX outputs.
- Reset mid-operation discards the in-flight slot. The next non-stalled edge after reset release loads normally.

Test Plan:
- Reset, then add r3,r1,r2 (0x00221820) with r1=5, r2=7 preloaded via WB -> next cycle o_valid=1, DA=5, DB=7, wr_addr=3, regWrite=1, aluOp=10.
- Same-cycle WB bypass: WB writes r1=0xDEAD while ID reads addi r2,r1,-1 (0x2022FFFF) -> DA=0xDEAD, immediate=0xFFFFFFFF, aluSrc=01.
- Load-use: i_ex_memRead=1, ex_wr_addr=4, ID holds add r5,r4,r0 -> o_hazard_stall=1, next cycle o_valid=0 with all controls 0. With ex_wr_addr=0 -> no stall.
- Flush and stall together -> flush wins (bubble). Stall alone for 3 cycles -> outputs unchanged.
- Branch wrap: beq with imm=0xFFFF, pcounter4=0x00000000 -> branch_target=0xFFFFFFFC. jal 0x0000010 with pc4=0x40000004 -> jump_target=0x40000040, wr_addr=31, link=0x40000004.
- Opcode 0x3F -> illegal=1, regWrite/memWrite=0. Writing r0 via WB, then reading it -> 0.
